weight_pair_streamer: RTL

//  Drives the weight register file's pair-write port. Reads one weight set from a 1-cycle-latency

---
 rtl/weight_stream_pkg.sv | 30 +++
 rtl/weight_addr_gen.sv | 25 ++
 rtl/weight_pair_streamer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and constants for the weight pair streamer and the
// conv-layer weight register file it feeds.
package weight_stream_pkg;

   // Beat counter width, shared with the register file's own counter.
   localparam int BEAT_W = 4;

   // Default register-file depth and its beat count.
   localparam int N_REG_DEF = 31;

   // Pairs per load: (N_REG+1)/2, since index 0 rides alone with w_1=0.
   function automatic int n_beats(input int n_reg);
      return (n_reg + 1) / 2;
   endfunction

   localparam int N_BEATS = n_beats(N_REG_DEF);

   typedef logic [BEAT_W-1:0] beat_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLEAR    = 3'd1,
      S_FETCH_HI = 3'd2,
      S_FETCH_LO = 3'd3,
      S_CAPTURE  = 3'd4,
      S_EMIT     = 3'd5,
      S_DONE     = 3'd6
   } state_e;

endpackage

// File: rtl/weight_addr_gen.sv
// Weight-memory address generator: maps (base, beat c, hi/lo) to an address.
// Ports: base (AW), c (beat), hi (1 = index 2c, 0 = index 2c-1), addr (AW).
// Arithmetic is modulo 2^AW; wrap-around is intentional.
module weight_addr_gen
   import weight_stream_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic [AW-1:0] base,
   input  beat_t         c,
   input  logic          hi,
   output logic [AW-1:0] addr
);

   logic [AW-1:0] off;

   always_comb begin
      off = {{(AW-BEAT_W-1){1'b0}}, c, 1'b0};
      if (!hi) begin
         off = off - {{(AW-1){1'b0}}, 1'b1};
      end
      addr = base + off;
   end

endmodule

// File: rtl/weight_pair_streamer.sv
// Streams one weight set from a 1-cycle-latency memory into the register
// file's pair-write port as (w_2, w_1) pairs, highest register index first.
// Ports: clk, rst (sync, active-high), start, base_addr, stall, abort,
//   mem_re/mem_addr/mem_rdata (weight memory), rf_clr, en, w_1, w_2
//   (register file), busy, done. Optional checksum output when
//   STREAM_CHECKSUM_EN is defined (wrapping sum of all emitted pairs).
module weight_pair_streamer
   import weight_stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_REG = 31,
   parameter int AW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic             stall,
   input  logic             abort,
   output logic             mem_re,
   output logic [AW-1:0]    mem_addr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             rf_clr,
   output logic             en,
   output logic [WIDTH-1:0] w_1,
   output logic [WIDTH-1:0] w_2,
   output logic             busy,
   output logic             done
`ifdef STREAM_CHECKSUM_EN
   ,
   output logic [WIDTH-1:0] checksum
`endif
);

   localparam int    NB     = n_beats(N_REG);
   localparam beat_t C_INIT = beat_t'(NB - 1);

   state_e           state_q, state_d;
   beat_t            c_q, c_d;
   logic [AW-1:0]    base_q, base_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] w_1_q, w_1_d;
   logic [WIDTH-1:0] w_2_q, w_2_d;
   logic             en_q, en_d;
   logic             rf_clr_q, rf_clr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             rd_hi;
   logic             rd_lo;
   logic             aborting;
   logic [AW-1:0]    gen_addr;

   assign aborting = abort && (state_q != S_IDLE);

   weight_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .base (base_q),
      .c    (c_q),
      .hi   (state_q == S_FETCH_HI),
      .addr (gen_addr)
   );

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      base_d  = base_q;
      hi_d    = hi_q;
      w_1_d   = w_1_q;
      w_2_d   = w_2_q;
      rd_hi   = 1'b0;
      rd_lo   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               c_d     = C_INIT;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_FETCH_HI;
         end
         S_FETCH_HI: begin
            if (!stall) begin
               rd_hi   = 1'b1;
               state_d = S_FETCH_LO;
            end
         end
         S_FETCH_LO: begin
            // Stage w_2 so the visible pair only changes on entry to EMIT.
            hi_d    = mem_rdata;
            rd_lo   = (c_q != '0);
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_2_d   = hi_q;
            w_1_d   = (c_q != '0) ? mem_rdata : '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (c_q == '0) begin
               state_d = S_DONE;
            end else begin
               c_d     = c_q - 1'b1;
               state_d = S_FETCH_HI;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort beats every other transition, including a pending stall.
      if (aborting) begin
         state_d = S_IDLE;
         c_d     = c_q;
         hi_d    = hi_q;
         w_1_d   = w_1_q;
         w_2_d   = w_2_q;
         rd_hi   = 1'b0;
         rd_lo   = 1'b0;
      end

      en_d     = (state_d == S_EMIT);
      rf_clr_d = (state_d == S_CLEAR);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         c_q      <= C_INIT;
         base_q   <= '0;
         hi_q     <= '0;
         w_1_q    <= '0;
         w_2_q    <= '0;
         en_q     <= 1'b0;
         rf_clr_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         base_q   <= base_d;
         hi_q     <= hi_d;
         w_1_q    <= w_1_d;
         w_2_q    <= w_2_d;
         en_q     <= en_d;
         rf_clr_q <= rf_clr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign mem_re   = rd_hi | rd_lo;
   assign mem_addr = mem_re ? gen_addr : '0;
   assign rf_clr   = rf_clr_q;
   // A same-cycle abort suppresses a strobe already registered high.
   assign en       = en_q & ~aborting;
   assign done     = done_q & ~aborting;
   assign busy     = busy_q;
   assign w_1      = w_1_q;
   assign w_2      = w_2_q;

`ifdef STREAM_CHECKSUM_EN
   logic [WIDTH-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q == S_CLEAR) begin
         sum_d = '0;
      end else if (state_q == S_EMIT && !aborting) begin
         sum_d = sum_q + w_1_q + w_2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign checksum = sum_q;
`endif

endmodule
